// File: rtl/rast_pkg.sv
// Shared constants and types for the rectangle rasterizer: draw modes,
// controller states and default screen geometry.
package rast_pkg;

    typedef enum logic [1:0] {
        MODE_FILL    = 2'd0,
        MODE_OUTLINE = 2'd1,
        MODE_ERASE   = 2'd2,
        MODE_RSVD    = 2'd3
    } rast_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } rast_state_e;

    localparam int DEF_SCREEN_W = 160;
    localparam int DEF_SCREEN_H = 120;

    // The reserved encoding behaves exactly like FILL.
    function automatic rast_mode_e decode_mode(input logic [1:0] m);
        rast_mode_e r;
        case (m)
            2'd1:    r = MODE_OUTLINE;
            2'd2:    r = MODE_ERASE;
            default: r = MODE_FILL;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/rect_rasterizer_if.sv
// Pixel output stream from the rasterizer to the plotting stage.
// A pixel transfers on a rising edge where pix_valid and pix_ready are both high;
// once pix_valid rises, pix_valid/x_out/y_out/colour_out stay stable until that edge.
interface rect_rasterizer_if #(
    parameter int XW = 8,
    parameter int YW = 7,
    parameter int CW = 3
) ();
    logic          pix_valid;
    logic          pix_ready;
    logic [XW-1:0] x_out;
    logic [YW-1:0] y_out;
    logic [CW-1:0] colour_out;

    modport master (
        output pix_valid, x_out, y_out, colour_out,
        input  pix_ready
    );

    modport slave (
        input  pix_valid, x_out, y_out, colour_out,
        output pix_ready
    );
endinterface

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: searches from the channel after the last granted one
// and advances its pointer only when the grant is accepted.
module rr_arbiter #(
    parameter  int NCH = 4,
    localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [NCH-1:0] req,
    input  logic           accept,
    output logic [NCH-1:0] grant,
    output logic [IW-1:0]  grant_idx,
    output logic           any_req
);
    logic [IW-1:0] ptr_q;
    int            idx;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_req   = 1'b0;
        idx       = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = int'(ptr_q) + i;
            if (idx >= NCH) idx = idx - NCH;
            if (!any_req && req[idx]) begin
                any_req    = 1'b1;
                grant[idx] = 1'b1;
                grant_idx  = IW'(idx);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ptr_q <= '0;
        end else if (accept && any_req) begin
            ptr_q <= (int'(grant_idx) == NCH - 1) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rect_rasterizer.sv
// Multi-channel rectangle rasterizer: grants one requester at a time and walks
// its rectangle row-major, emitting clipped FILL/OUTLINE/ERASE pixels.
module rect_rasterizer
    import rast_pkg::*;
#(
    parameter  int NCH      = 4,
    parameter  int XW       = 8,
    parameter  int YW       = 7,
    parameter  int CW       = 3,
    parameter  int SCREEN_W = DEF_SCREEN_W,
    parameter  int SCREEN_H = DEF_SCREEN_H,
    localparam int IW       = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [NCH-1:0]    req,
    input  logic [NCH*XW-1:0] x_pos,
    input  logic [NCH*YW-1:0] y_pos,
    input  logic [NCH*XW-1:0] width,
    input  logic [NCH*YW-1:0] height,
    input  logic [NCH*CW-1:0] colour,
    input  logic [NCH*2-1:0]  mode,
    input  logic [CW-1:0]     bg_colour,
    output logic [NCH-1:0]    ack,
    output logic [NCH-1:0]    done,
    output logic              busy,
    rect_rasterizer_if.master pix,
    output rast_state_e       state_dbg
);
    localparam logic [XW:0] SW_L = (XW+1)'(SCREEN_W);
    localparam logic [YW:0] SH_L = (YW+1)'(SCREEN_H);

    rast_state_e   state_q, state_d;
    logic [IW-1:0] ch_q;
    logic [XW-1:0] lx_q, lw_q, col_q;
    logic [YW-1:0] ly_q, lh_q, row_q;
    logic [CW-1:0] lcol_q;
    rast_mode_e    lmode_q;

    logic [NCH-1:0] grant;
    logic [IW-1:0]  grant_idx;
    logic           any_req;
    logic           accept;

    logic [XW:0] x_sum;
    logic [YW:0] y_sum;
    logic        empty, col_last, row_last, on_border, visible;
    logic        emit, advance, final_px;
    rast_mode_e  new_mode;

    assign accept = (state_q == ST_IDLE) && reset_n;

    rr_arbiter #(.NCH(NCH)) u_arb (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .accept    (accept),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_req   (any_req)
    );

    // Extra sum bit keeps off-screen coordinates from wrapping back on-screen.
    always_comb begin
        x_sum     = {1'b0, lx_q} + {1'b0, col_q};
        y_sum     = {1'b0, ly_q} + {1'b0, row_q};
        empty     = (lw_q == '0) || (lh_q == '0);
        col_last  = (col_q == lw_q - 1'b1);
        row_last  = (row_q == lh_q - 1'b1);
        on_border = (col_q == '0) || col_last || (row_q == '0) || row_last;
        visible   = (x_sum < SW_L) && (y_sum < SH_L);
        emit      = (state_q == ST_SCAN) && !empty && visible &&
                    ((lmode_q != MODE_OUTLINE) || on_border);
        advance   = (state_q == ST_SCAN) && (!emit || pix.pix_ready);
        final_px  = empty || (col_last && row_last);
        new_mode  = decode_mode(mode[grant_idx*2 +: 2]);
    end

    always_comb begin
        state_d = state_q;
        ack     = '0;
        done    = '0;
        case (state_q)
            ST_IDLE: begin
                if (reset_n && any_req) begin
                    ack     = grant;
                    state_d = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (advance && final_px) state_d = ST_DONE;
            end
            ST_DONE: begin
                done    = NCH'(1) << ch_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // ERASE resolves its colour at grant time so the walk only carries one colour.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            ch_q    <= '0;
            lx_q    <= '0;
            ly_q    <= '0;
            lw_q    <= '0;
            lh_q    <= '0;
            lcol_q  <= '0;
            lmode_q <= MODE_FILL;
            col_q   <= '0;
            row_q   <= '0;
        end else if (state_q == ST_IDLE && any_req) begin
            ch_q    <= grant_idx;
            lx_q    <= x_pos[grant_idx*XW +: XW];
            ly_q    <= y_pos[grant_idx*YW +: YW];
            lw_q    <= width[grant_idx*XW +: XW];
            lh_q    <= height[grant_idx*YW +: YW];
            lcol_q  <= (new_mode == MODE_ERASE) ? bg_colour : colour[grant_idx*CW +: CW];
            lmode_q <= new_mode;
            col_q   <= '0;
            row_q   <= '0;
        end else if (advance && !final_px) begin
            if (col_last) begin
                col_q <= '0;
                row_q <= row_q + 1'b1;
            end else begin
                col_q <= col_q + 1'b1;
            end
        end
    end

    assign busy           = (state_q != ST_IDLE);
    assign pix.pix_valid  = emit;
    assign pix.x_out      = x_sum[XW-1:0];
    assign pix.y_out      = y_sum[YW-1:0];
    assign pix.colour_out = lcol_q;
    assign state_dbg      = state_q;

endmodule

// File: tb/tb_rect_rasterizer.sv
// Directed bench for rect_rasterizer: a reference rectangle walker fills the
// expected pixel queue, a negedge monitor logs accepted pixels, acks and dones.
module tb_rect_rasterizer;
    import rast_pkg::*;

    localparam int NCH = 4;
    localparam int XW  = 8;
    localparam int YW  = 7;
    localparam int CW  = 3;
    localparam int PW  = XW + YW + CW;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [NCH-1:0]    req = '0;
    logic [NCH*XW-1:0] x_pos = '0;
    logic [NCH*YW-1:0] y_pos = '0;
    logic [NCH*XW-1:0] width = '0;
    logic [NCH*YW-1:0] height = '0;
    logic [NCH*CW-1:0] colour = '0;
    logic [NCH*2-1:0]  mode = '0;
    logic [CW-1:0]     bg_colour = '0;
    logic [NCH-1:0]    ack, done;
    logic              busy;
    rast_state_e       state_dbg;

    rect_rasterizer_if #(.XW(XW), .YW(YW), .CW(CW)) pix ();

    rect_rasterizer #(.NCH(NCH), .XW(XW), .YW(YW), .CW(CW)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .req       (req),
        .x_pos     (x_pos),
        .y_pos     (y_pos),
        .width     (width),
        .height    (height),
        .colour    (colour),
        .mode      (mode),
        .bg_colour (bg_colour),
        .ack       (ack),
        .done      (done),
        .busy      (busy),
        .pix       (pix.master),
        .state_dbg (state_dbg)
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- scoreboard state ----------------
    logic [PW-1:0]  exp_q[$];
    logic [PW-1:0]  obs_q[$];
    int             obs_cyc_q[$];
    logic [NCH-1:0] ack_log[$];
    logic [NCH-1:0] done_log[$];
    int             hold_viol = 0;
    int             cyc = 0;
    int             rd = 0;
    int             checks = 0;
    int             errors = 0;

    // ---------------- monitor ----------------
    logic          pend = 1'b0;
    logic [PW-1:0] pend_px = '0;
    logic [PW-1:0] cur;
    assign cur = {pix.x_out, pix.y_out, pix.colour_out};

    always @(negedge clock) begin
        cyc = cyc + 1;
        if (pend && !(pix.pix_valid && cur == pend_px)) hold_viol = hold_viol + 1;
        pend    = reset_n && pix.pix_valid && !pix.pix_ready;
        pend_px = cur;
        if (reset_n && pix.pix_valid && pix.pix_ready) begin
            obs_q.push_back(cur);
            obs_cyc_q.push_back(cyc);
        end
        if (ack != '0)  ack_log.push_back(ack);
        if (done != '0) done_log.push_back(done);
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int ch, input int x, input int y, input int w,
                          input int h, input int c, input int m);
        x_pos[ch*XW +: XW]  = XW'(x);
        y_pos[ch*YW +: YW]  = YW'(y);
        width[ch*XW +: XW]  = XW'(w);
        height[ch*YW +: YW] = YW'(h);
        colour[ch*CW +: CW] = CW'(c);
        mode[ch*2 +: 2]     = 2'(m);
    endtask

    // Reference walker: row-major, clipped, outline-filtered.
    task automatic push_rect(input int x, input int y, input int w, input int h,
                             input int m, input int c, input int bg);
        logic [XW-1:0] xb;
        logic [YW-1:0] yb;
        logic [CW-1:0] cb;
        int xs, ys;
        cb = (m == 2) ? CW'(bg) : CW'(c);
        for (int r = 0; r < h; r++) begin
            for (int k = 0; k < w; k++) begin
                xs = x + k;
                ys = y + r;
                if (xs < 160 && ys < 120 &&
                    (m != 1 || k == 0 || k == w - 1 || r == 0 || r == h - 1)) begin
                    xb = xs[XW-1:0];
                    yb = ys[YW-1:0];
                    exp_q.push_back({xb, yb, cb});
                end
            end
        end
    endtask

    task automatic tick(input bit rnd);
        @(posedge clock);
        #1;
        if (rnd) pix_ready_drive(1'($urandom_range(0, 1)));
    endtask

    task automatic pix_ready_drive(input logic v);
        pix.pix_ready = v;
    endtask

    task automatic wait_acks(input int n, input int budget, input bit rnd);
        for (int k = 0; k < budget && ack_log.size() < n; k++) tick(rnd);
    endtask

    task automatic wait_dones(input int n, input int budget, input bit rnd);
        for (int k = 0; k < budget && done_log.size() < n; k++) tick(rnd);
    endtask

    task automatic run_rect(input string tag, input int ch, input int x, input int y,
                            input int w, input int h, input int c, input int m,
                            input bit rnd, input bit scramble);
        int na, nd;
        na = ack_log.size() + 1;
        nd = done_log.size() + 1;
        set_ch(ch, x, y, w, h, c, m);
        req[ch] = 1'b1;
        wait_acks(na, 50, rnd);
        req[ch] = 1'b0;
        if (scramble) set_ch(ch, x + 3, y + 7, w + 2, h + 1, c ^ 1, 0);
        check({tag, " ack count"}, ack_log.size(), na);
        if (ack_log.size() >= na) check({tag, " ack ch"}, ack_log[na-1], 1 << ch);
        wait_dones(nd, 2000, rnd);
        check({tag, " done count"}, done_log.size(), nd);
        if (done_log.size() >= nd) check({tag, " done ch"}, done_log[nd-1], 1 << ch);
    endtask

    task automatic drain(input string tag);
        int n_obs, n_exp;
        n_obs = obs_q.size() - rd;
        n_exp = exp_q.size();
        check({tag, " pixel count"}, n_obs, n_exp);
        for (int i = 0; i < n_exp; i++) begin
            if (i < n_obs) check({tag, " pixel"}, obs_q[rd+i], exp_q.pop_front());
        end
        exp_q.delete();
        rd = obs_q.size();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        logic [NCH-1:0] ord[4];
        int s, na, nd, hv;
        ord[0] = 4'b0001; ord[1] = 4'b0010; ord[2] = 4'b1000; ord[3] = 4'b0001;
        pix.pix_ready = 1'b1;

        // Reset values
        repeat (3) @(posedge clock);
        @(negedge clock);
        check("reset busy", busy, 0);
        check("reset pix_valid", pix.pix_valid, 0);
        check("reset ack", ack, 0);
        check("reset done", done, 0);
        check("reset x_out", pix.x_out, 0);
        check("reset y_out", pix.y_out, 0);
        check("reset colour_out", pix.colour_out, 0);
        check("reset state", state_dbg, ST_IDLE);
        @(posedge clock);
        #1;
        reset_n = 1'b1;

        // FILL 3x2 at (10,20), back-to-back pixels
        push_rect(10, 20, 3, 2, 0, 5, 0);
        s = obs_q.size();
        run_rect("t1", 0, 10, 20, 3, 2, 5, 0, 1'b0, 1'b0);
        check("t1 pixels", obs_q.size() - s, 6);
        if (obs_q.size() >= s + 6) check("t1 consecutive", obs_cyc_q[s+5] - obs_cyc_q[s], 5);
        drain("t1");

        // OUTLINE 4x3 at origin
        push_rect(0, 0, 4, 3, 1, 3, 0);
        s = obs_q.size();
        run_rect("t2", 1, 0, 0, 4, 3, 3, 1, 1'b0, 1'b0);
        check("t2 pixels", obs_q.size() - s, 10);
        drain("t2");

        // FILL clipped at the bottom-right corner
        push_rect(158, 118, 4, 4, 0, 6, 0);
        s = obs_q.size();
        run_rect("t3", 2, 158, 118, 4, 4, 6, 0, 1'b0, 1'b0);
        check("t3 pixels", obs_q.size() - s, 4);
        drain("t3");

        // Zero-width rectangle: done with no pixels
        run_rect("t3z", 1, 5, 5, 0, 3, 2, 0, 1'b0, 1'b0);
        drain("t3z");

        // Round robin from reset with req=1011 held
        do_reset();
        set_ch(0, 20, 5, 1, 1, 1, 0);
        set_ch(1, 30, 5, 1, 1, 2, 0);
        set_ch(3, 40, 5, 1, 1, 4, 0);
        push_rect(20, 5, 1, 1, 0, 1, 0);
        push_rect(30, 5, 1, 1, 0, 2, 0);
        push_rect(40, 5, 1, 1, 0, 4, 0);
        push_rect(20, 5, 1, 1, 0, 1, 0);
        na = ack_log.size();
        nd = done_log.size();
        req = 4'b1011;
        wait_acks(na + 4, 200, 1'b0);
        req = '0;
        wait_dones(nd + 4, 200, 1'b0);
        check("t4 ack count", ack_log.size() - na, 4);
        check("t4 done count", done_log.size() - nd, 4);
        for (int i = 0; i < 4; i++) begin
            if (na + i < ack_log.size())  check("t4 ack order", ack_log[na+i], ord[i]);
            if (nd + i < done_log.size()) check("t4 done order", done_log[nd+i], ord[i]);
        end
        drain("t4");

        // ERASE with random back-pressure, inputs scrambled mid-draw
        bg_colour = '0;
        hv = hold_viol;
        push_rect(50, 60, 5, 3, 2, 7, 0);
        run_rect("t5", 3, 50, 60, 5, 3, 7, 2, 1'b1, 1'b1);
        pix.pix_ready = 1'b1;
        check("t5 hold stable", hold_viol - hv, 0);
        drain("t5");

        // Reset in the middle of a scan
        set_ch(0, 0, 0, 10, 10, 1, 0);
        na = ack_log.size() + 1;
        req[0] = 1'b1;
        wait_acks(na, 50, 1'b0);
        req[0] = 1'b0;
        repeat (5) @(posedge clock);
        #1;
        check("t6 busy mid-scan", busy, 1);
        check("t6 valid mid-scan", pix.pix_valid, 1);
        nd = done_log.size();
        reset_n = 1'b0;
        @(posedge clock);
        #1;
        check("t6 busy after reset", busy, 0);
        check("t6 valid after reset", pix.pix_valid, 0);
        check("t6 state after reset", state_dbg, ST_IDLE);
        repeat (3) @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check("t6 no done", done_log.size(), nd);
        check("t6 idle after release", busy, 0);
        rd = obs_q.size();
        exp_q.delete();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/rect_rasterizer.md
RECT_RASTERIZER -- requirements
Module: rect_rasterizer

Interface
REQ-001 SHALL have parameter NCH, default 4: number of requesting channels (paddles, puck, score bar).
REQ-002 SHALL have parameter XW, default 8: x coordinate and width bits.
REQ-003 SHALL have parameter YW, default 7: y coordinate and height bits.
REQ-004 SHALL have parameter CW, default 3: colour bits.
REQ-005 SHALL have parameter SCREEN_W, default 160: visible columns.
REQ-006 SHALL have parameter SCREEN_H, default 120: visible rows.
REQ-007 SHALL have port clock, input, 1: rising-edge clock.
REQ-008 SHALL have port reset_n, input, 1: reset, synchronous, active-low.
REQ-009 SHALL have port req, input, NCH: per-channel draw request, level, held until ack.
REQ-010 SHALL have port x_pos, input, NCH*XW: per-channel top-left x.
REQ-011 SHALL have port y_pos, input, NCH*YW: per-channel top-left y.
REQ-012 SHALL have port width, input, NCH*XW: per-channel pixel count in x.
REQ-013 SHALL have port height, input, NCH*YW: per-channel pixel count in y.
REQ-014 SHALL have port colour, input, NCH*CW: per-channel draw colour.
REQ-015 SHALL have port mode, input, NCH*2: per-channel mode, 0 FILL, 1 OUTLINE, 2 ERASE, 3 reserved (treated as FILL).
REQ-016 SHALL have port bg_colour, input, CW: colour used by ERASE.
REQ-017 SHALL have port ack, output, NCH: one-cycle pulse when a channel's request is latched.
REQ-018 SHALL have port done, output, NCH: one-cycle pulse when that channel's rectangle completes.
REQ-019 SHALL have port busy, output, 1: high outside IDLE.
REQ-020 SHALL have port pix_valid, output, 1: pixel output valid.
REQ-021 SHALL have port pix_ready, input, 1: downstream (VGA plot) accepts pixel.
REQ-022 SHALL have ports x_out XW, y_out YW, colour_out CW, outputs: pixel coordinate and colour.

Function
REQ-023 SHALL implement FSM states IDLE, SCAN, DONE.
REQ-024 In IDLE with any req bit high, SHALL grant one channel round-robin, starting after the last granted channel.
REQ-025 On grant, SHALL pulse ack[ch], latch that channel's x/y/width/height/colour/mode, zero col/row counters, and enter SCAN on the next edge.
REQ-026 SCAN SHALL visit (col,row) in row-major order, col 0..width-1 fastest, row 0..height-1.
REQ-027 x_out/y_out SHALL equal x_pos+col and y_pos+row; sums SHALL be computed in XW+1 and YW+1 bits with no wrap.
REQ-028 A visited pixel SHALL be emitted only if x sum < SCREEN_W, y sum < SCREEN_H, and, in OUTLINE, col is 0 or width-1, or row is 0 or height-1.
REQ-029 A non-emitted pixel SHALL advance counters in one cycle with pix_valid low.
REQ-030 An emitted pixel SHALL hold pix_valid and outputs stable until pix_ready high; counters SHALL advance only on pix_valid&pix_ready.
REQ-031 colour_out SHALL be bg_colour in ERASE, else the latched colour.
REQ-032 After the last pixel (row height-1, col width-1) is accepted or skipped, SHALL enter DONE, pulse done[ch] for one cycle, then return to IDLE.
REQ-033 width=0 or height=0 SHALL emit no pixels and go SCAN->DONE in one cycle.
REQ-034 Requests during SCAN/DONE SHALL be ignored until IDLE; the latched geometry SHALL not change if inputs change mid-draw.
REQ-035 Peak throughput SHALL be one pixel per cycle with pix_ready held high.

Reset
REQ-036 On reset_n low at a clock edge, SHALL enter IDLE, abandon any draw without done, and clear ack, done, busy, and pix_valid to 0.
REQ-037 On reset, x_out, y_out, colour_out, counters, and latched fields SHALL be 0; the round-robin pointer SHALL select channel 0 first.

Structure
REQ-038 The mode encodings and default screen constants SHALL live in a shared package, rast_pkg.
REQ-039 The round-robin grant SHALL be a sub-module, rr_arbiter (parameter NCH; req in; one-hot grant and pointer update on accept).
REQ-040 Target size SHALL be 150-300 lines of RTL.

Verification
REQ-041 The bench SHALL drive ch0 FILL x=10 y=20 w=3 h=2 with pix_ready=1 -> 6 pixels (10,20),(11,20),(12,20),(10,21),(11,21),(12,21) on consecutive cycles, then done[0].
REQ-042 The bench SHALL drive OUTLINE w=4 h=3 at (0,0) -> 10 pixels; (1,1) and (2,1) are never emitted.
REQ-043 The bench SHALL drive FILL x=158 y=118 w=4 h=4 -> only (158..159,118..119) emitted, 4 pixels, done pulses.
REQ-044 The bench SHALL assert req=4'b1011 continuously -> ack order ch0, ch1, ch3, ch0; one done per ack.
REQ-045 The bench SHALL toggle pix_ready randomly during ERASE with bg_colour=0 -> no pixel dropped or duplicated; colour_out=0 throughout.
REQ-046 The bench SHALL assert reset_n=0 mid-SCAN -> next cycle busy=0 and pix_valid=0, with no done pulse.
